// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // no request outstanding
    S_BUSY  = 2'd1,  // request outstanding, returned word will be queued
    S_FLUSH = 2'd2   // request outstanding, returned word will be dropped
  } fetch_state_e;

  // Default fetch address after reset; matches the PC reset value
  localparam logic [31:0] RESET_ADDR_DEF = 32'h1A000000;

  // One queued entry: fetch address in the upper half, instruction below
  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a single-cycle flush. Flush wins over push and pop.
// Storage is not reset; the head reads as zero while the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage, written only on a non-flushed push
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Head entry, forced to zero when empty so reset shows a clean output
  always_comb begin
    head = '0;
    if (count != '0) head = mem[rd_ptr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: single-outstanding memory requests feeding a
// small address+instruction queue for decode, with branch-redirect discard.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] PC_IN,
  output logic        PC_ENABLE,
  input  logic        REDIRECT,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt;
  logic             push, pop, room_after;
  fetch_entry_t     head, din;

  // A redirect cycle ignores the decoder handshake; the queue is flushed instead
  assign pop = INSTR_VALID & INSTR_READY & ~REDIRECT;

  // Will the queue still have space after this cycle's push (and pop)?
  assign room_after = pop ? (cnt < CNT_W'(DEPTH)) : (cnt < CNT_W'(DEPTH - 1));

  assign din = '{pc: addr_q, instr: MEM_RDATA};

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RES),
    .push  (push),
    .pop   (pop),
    .flush (REDIRECT),
    .din   (din),
    .head  (head),
    .count (cnt)
  );

  // State and fetch address registers
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= S_IDLE;
      addr_q  <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next state, next address, PC advance and queue push
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    PC_ENABLE = 1'b0;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // PC_IN is stale during a redirect, so wait one cycle before issuing
        if (!REDIRECT && (cnt < CNT_W'(DEPTH))) begin
          addr_d  = PC_IN;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (REDIRECT) begin
          state_d = MEM_ACK ? S_IDLE : S_FLUSH;
        end else if (MEM_ACK) begin
          push      = 1'b1;
          PC_ENABLE = 1'b1;
          if (room_after) addr_d  = addr_q + 32'd4;
          else            state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        // The outstanding request must complete; its data is discarded
        if (MEM_ACK) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign MEM_REQ     = (state_q != S_IDLE);
  assign MEM_ADDR    = addr_q;
  assign INSTR_VALID = (cnt != '0);
  assign INSTR       = head.instr;
  assign INSTR_PC    = head.pc;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end that sits between the program counter register and the decode stage. It reads instruction words from instruction memory over a single-outstanding req/ack interface and queues them with their addresses in a small FIFO for the decoder. It advances the program counter through its `PC_ENABLE` output and discards in-flight fetches when the decoder signals a branch redirect.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `RESET_ADDR`, 32'h1A000000: fetch address after reset; equals the program counter reset value.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RES` input 1: reset, asynchronous and active-high.
- `PC_IN` input 32: current program counter value.
- `PC_ENABLE` output 1: one-cycle strobe; advances the PC by 4.
- `REDIRECT` input 1: branch taken. In the same cycle the PC loads its new target.
- `MEM_REQ` output 1: fetch request.
- `MEM_ADDR` output 32: fetch address. Stable while `MEM_REQ` is high.
- `MEM_ACK` input 1: read data is valid this cycle; completes the request.
- `MEM_RDATA` input 32: instruction word.
- `INSTR` output 32: instruction at the FIFO head.
- `INSTR_PC` output 32: address of `INSTR`.
- `INSTR_VALID` output 1: FIFO is not empty.
- `INSTR_READY` input 1: decoder accepts the head entry.

## Operation
- Top-level PC hookup:
  - pc.ENABLE = `PC_ENABLE` | `REDIRECT`
  - pc.MODE = `REDIRECT`
- FSM states:
  - IDLE: no request outstanding.
  - BUSY: request outstanding, data will be kept.
  - FLUSH: request outstanding, data will be discarded.
- IDLE:
  - If `REDIRECT` is high, stay in IDLE. Do not issue, because `PC_IN` is stale this cycle.
  - Else if count < DEPTH: `MEM_ADDR`<=`PC_IN`, go to BUSY.
- BUSY, `MEM_ACK` with no `REDIRECT`:
  - Push {`MEM_ADDR`, `MEM_RDATA`}.
  - `PC_ENABLE`=1 this cycle.
  - If count_next < DEPTH: stay in BUSY with `MEM_ADDR`<=`MEM_ADDR`+4, giving back-to-back fetch. Otherwise go to IDLE.
  - count_next = count + 1 − pop.
- BUSY, `REDIRECT` with `MEM_ACK`: drop the data, `PC_ENABLE`=0, go to IDLE.
- BUSY, `REDIRECT` without `MEM_ACK`: go to FLUSH.
- FLUSH:
  - Hold `MEM_REQ` and `MEM_ADDR`.
  - On `MEM_ACK`: drop the data, `PC_ENABLE`=0, go to IDLE.
  - A further `REDIRECT` in FLUSH leaves the state unchanged.
- `MEM_REQ` = (state != IDLE). A request is never withdrawn before `MEM_ACK`.
- `PC_ENABLE` = BUSY & `MEM_ACK` & ~`REDIRECT`. It is never high in any other case.
- FIFO:
  - Pop on `INSTR_VALID` & `INSTR_READY`.
  - `REDIRECT` empties the FIFO at the edge. This flush has priority over push and pop, and the handshake in a redirect cycle is ignored.
  - Push never occurs when full; the issue rule guarantees this.
  - Pointers wrap modulo DEPTH. count has range 0..DEPTH.
- Addresses: `MEM_ADDR`+4 is computed modulo 2^32, so 32'hFFFFFFFC wraps to 0.

## Timing
- Reset values, asynchronous:
  - state IDLE, count 0
  - `MEM_REQ`=0, `MEM_ADDR`=RESET_ADDR
  - `PC_ENABLE`=0, `INSTR_VALID`=0
  - `INSTR`=0, `INSTR_PC`=0
- Reset mid-request abandons the request. Memory must tolerate this.
- First `MEM_REQ` appears in the cycle after the first clock edge with `RES` low.
- Ack to `INSTR_VALID` latency is 1 cycle (no bypass).
- Throughput: one instruction per cycle when `MEM_ACK` returns in the same cycle as `MEM_REQ` and the decoder drains.
- Redirect in IDLE: the new request issues 1 cycle later, with `MEM_ADDR` equal to the target.
- Redirect in BUSY: the new request issues in the cycle after the discarded ack.

## Structure
- Package `fetch_pkg` holds:
  - state encoding constants (IDLE, BUSY, FLUSH)
  - `RESET_ADDR` default
  - fetch entry width (64 bits = address + instruction)
- Sub-module `fetch_fifo`:
  - synchronous FIFO with flush
  - parameters DEPTH and width 64
  - ports push/pop/flush/count/head
- The FSM and address register live in `instr_fetch`.

## Test plan
- Reset release, memory acks immediately, `INSTR_READY`=1:
  - `MEM_ADDR` sequence is 1A000000, 1A000004, 1A000008 on consecutive cycles.
  - `INSTR_VALID` rises 1 cycle after the first ack.
  - `PC_ENABLE` pulses once per ack.
- `INSTR_READY`=0, immediate acks:
  - Exactly 4 fetches occur, then `MEM_REQ`=0 and count=4.
  - Raising `INSTR_READY` for 1 cycle triggers one new fetch, at 1A000010.
- Ack delayed 3 cycles:
  - `MEM_REQ` and `MEM_ADDR` are held stable for all 3 cycles.
  - `PC_ENABLE` is high only in the ack cycle.
- `REDIRECT` in BUSY 1 cycle before a delayed ack, target 1A000100:
  - The FIFO empties.
  - The acked word is dropped with no `PC_ENABLE`.
  - The next `MEM_ADDR` is 1A000100 and its entry has `INSTR_PC`=1A000100.
- `REDIRECT` in the same cycle as `MEM_ACK` and a pop:
  - Data is dropped, count becomes 0, `PC_ENABLE` stays 0.
  - The state passes through IDLE, then a request issues from the new `PC_IN`.
- `RES` asserted while in BUSY with 2 entries queued:
  - Outputs immediately return to their reset values.
  - After release, fetching restarts at 1A000000.
